// File: rtl/llki_discrete_key_sender.sv
`default_nettype none
// ============================================================================
// Module   : llki_discrete_key_sender
// Purpose  : Initiator side of the LLKI discrete key interface. Holds a local
//            buffer of KEY_WORDS 64-bit key words and, on command, streams
//            them to a core's key FSM (data/valid/ready) and waits for
//            key_complete, or raises a clear-key request and waits for ack.
// Ports    : clk_i, rst_ni             clock, async active-low reset
//            kbuf_we_i/addr_i/wdata_i  key-buffer write port (idle only)
//            cmd_valid_i/op_i/ready_o  command handshake (00 LOAD, 01 CLEAR)
//            busy_o, done_o, status_o  progress and completion status
//            llkid_*                   key interface towards the core
// Revision : 1.0 - initial release
// ============================================================================
module llki_discrete_key_sender #(
   parameter int KEY_WORDS      = 5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        kbuf_we_i,
   input  logic [5:0]  kbuf_addr_i,
   input  logic [63:0] kbuf_wdata_i,
   input  logic        cmd_valid_i,
   input  logic [1:0]  cmd_op_i,
   output logic        cmd_ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  status_o,
   output logic [63:0] llkid_key_data_o,
   output logic        llkid_key_valid_o,
   input  logic        llkid_key_ready_i,
   input  logic        llkid_key_complete_i,
   output logic        llkid_clear_key_o,
   input  logic        llkid_clear_key_ack_i
);

   localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(KEY_WORDS - 1);
   localparam logic [TMO_W-1:0] C_TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] C_TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [6:0]       C_KEY_WORDS   = 7'(KEY_WORDS);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SEND      = 3'd1;
   localparam logic [2:0] S_WAIT_CMPL = 3'd2;
   localparam logic [2:0] S_CLEAR     = 3'd3;
   localparam logic [2:0] S_FINISH    = 3'd4;

   localparam logic [1:0] C_ST_OK      = 2'b00;
   localparam logic [1:0] C_ST_TIMEOUT = 2'b01;
   localparam logic [1:0] C_ST_EARLY   = 2'b10;
   localparam logic [1:0] C_ST_ILLEGAL = 2'b11;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [1:0]       status_q, status_d;
   logic [63:0]      data_q, data_d;

   logic [63:0]      kbuf_q [KEY_WORDS];
   logic             kbuf_wr_en;
   logic [IDX_W-1:0] idx_inc;
   logic [TMO_W-1:0] tmo_inc;
   logic             tmo_hit;
   logic             xfer;

   // Key buffer: no reset, contents are undefined until software writes them.
   // The range check keeps out-of-range addresses from aliasing via truncation.
   assign kbuf_wr_en = kbuf_we_i && (state_q == S_IDLE) && ({1'b0, kbuf_addr_i} < C_KEY_WORDS);

   always_ff @(posedge clk_i) begin
      if (kbuf_wr_en) begin
         kbuf_q[kbuf_addr_i[IDX_W-1:0]] <= kbuf_wdata_i;
      end
   end

   assign idx_inc = idx_q + 1'b1;
   assign tmo_inc = (tmo_q == C_TMO_MAX) ? tmo_q : tmo_q + 1'b1;
   // Hit on the TIMEOUT_CYCLES-th consecutive cycle without progress.
   assign tmo_hit = (tmo_q >= C_TMO_LAST);
   assign xfer    = (state_q == S_SEND) && llkid_key_ready_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         tmo_q    <= '0;
         status_q <= C_ST_OK;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         status_q <= status_d;
         data_q   <= data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmo_d    = tmo_inc;
      status_d = status_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            // Counter held at zero so every wait phase starts from a clean count.
            tmo_d = '0;
            if (cmd_valid_i) begin
               case (cmd_op_i)
                  2'b00: begin
                     state_d = S_SEND;
                     idx_d   = '0;
                     data_d  = kbuf_q[0];
                  end
                  2'b01: state_d = S_CLEAR;
                  default: begin
                     state_d  = S_FINISH;
                     status_d = C_ST_ILLEGAL;
                  end
               endcase
            end
         end
         S_SEND: begin
            // Last-word transfer beats a simultaneous complete: that is success.
            if (xfer && (idx_q == C_LAST_IDX)) begin
               state_d = S_WAIT_CMPL;
               tmo_d   = '0;
            end else if (llkid_key_complete_i) begin
               state_d  = S_FINISH;
               status_d = C_ST_EARLY;
            end else if (xfer) begin
               idx_d  = idx_inc;
               data_d = kbuf_q[idx_inc];
               tmo_d  = '0;
            end else if (tmo_hit) begin
               state_d  = S_FINISH;
               status_d = C_ST_TIMEOUT;
            end
         end
         S_WAIT_CMPL: begin
            if (llkid_key_complete_i) begin
               state_d  = S_FINISH;
               status_d = C_ST_OK;
            end else if (tmo_hit) begin
               state_d  = S_FINISH;
               status_d = C_ST_TIMEOUT;
            end
         end
         S_CLEAR: begin
            if (llkid_clear_key_ack_i) begin
               state_d  = S_FINISH;
               status_d = C_ST_OK;
            end else if (tmo_hit) begin
               state_d  = S_FINISH;
               status_d = C_ST_TIMEOUT;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decode the registered state only; no input reaches an output.
   always_comb begin
      cmd_ready_o       = (state_q == S_IDLE);
      busy_o            = (state_q != S_IDLE);
      done_o            = (state_q == S_FINISH);
      status_o          = status_q;
      llkid_key_valid_o = (state_q == S_SEND);
      llkid_key_data_o  = data_q;
      llkid_clear_key_o = (state_q == S_CLEAR);
   end

endmodule
`default_nettype wire

// File: tb/tb_llki_discrete_key_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_llki_discrete_key_sender
// Purpose  : Directed self-checking bench for llki_discrete_key_sender
//            (KEY_WORDS=5, TIMEOUT_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_llki_discrete_key_sender;

   localparam int KW  = 5;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        kbuf_we;
   logic [5:0]  kbuf_addr;
   logic [63:0] kbuf_wdata;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [63:0] key_data;
   logic        key_valid;
   logic        key_ready;
   logic        key_complete;
   logic        clear_key;
   logic        clear_ack;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] buf3 [KW];

   always #5 clk = ~clk;

   llki_discrete_key_sender #(
      .KEY_WORDS      (KW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .kbuf_we_i             (kbuf_we),
      .kbuf_addr_i           (kbuf_addr),
      .kbuf_wdata_i          (kbuf_wdata),
      .cmd_valid_i           (cmd_valid),
      .cmd_op_i              (cmd_op),
      .cmd_ready_o           (cmd_ready),
      .busy_o                (busy),
      .done_o                (done),
      .status_o              (status),
      .llkid_key_data_o      (key_data),
      .llkid_key_valid_o     (key_valid),
      .llkid_key_ready_i     (key_ready),
      .llkid_key_complete_i  (key_complete),
      .llkid_clear_key_o     (clear_key),
      .llkid_clear_key_ack_i (clear_ack)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kbuf_write(input logic [5:0] a, input logic [63:0] d);
      kbuf_we    = 1'b1;
      kbuf_addr  = a;
      kbuf_wdata = d;
      tick();
      kbuf_we    = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
   endtask

   task automatic wait_done(input int max);
      int k;
      k = 0;
      while (!done && k < max) begin
         tick();
         k++;
      end
      check_eq("done_seen", {63'd0, done}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int exp_idx;

      rst_n = 1'b0; kbuf_we = 1'b0; kbuf_addr = '0; kbuf_wdata = '0;
      cmd_valid = 1'b0; cmd_op = 2'b00;
      key_ready = 1'b0; key_complete = 1'b0; clear_ack = 1'b0;
      buf3[0] = 64'hA5A5_0000_1111_0001;
      buf3[1] = 64'h5A5A_0000_2222_0002;
      buf3[2] = 64'hFFFF_0000_3333_0003;
      buf3[3] = 64'h0123_4567_89AB_CDEF;
      buf3[4] = 64'hFEDC_BA98_7654_3210;

      // ---------------- reset state ----------------
      tick(); tick(); tick();
      check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check_eq("rst_busy",      {63'd0, busy},      64'd0);
      check_eq("rst_done",      {63'd0, done},      64'd0);
      check_eq("rst_valid",     {63'd0, key_valid}, 64'd0);
      check_eq("rst_clear",     {63'd0, clear_key}, 64'd0);
      check_eq("rst_status",    {62'd0, status},    64'd0);
      check_eq("rst_data",      key_data,           64'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- back-to-back LOAD, ready stuck high ----------------
      for (int i = 0; i < KW; i++) kbuf_write(6'(i), 64'(i + 1));
      key_ready = 1'b1;
      issue(2'b00);
      check_eq("t2_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check_eq("t2_busy",      {63'd0, busy},      64'd1);
      for (int i = 0; i < KW; i++) begin
         check_eq("t2_valid", {63'd0, key_valid}, 64'd1);
         check_eq("t2_data",  key_data,           64'(i + 1));
         tick();
      end
      check_eq("t2_valid_low", {63'd0, key_valid}, 64'd0);
      check_eq("t2_busy_wait", {63'd0, busy},      64'd1);
      check_eq("t2_no_done",   {63'd0, done},      64'd0);
      tick();
      check_eq("t2_no_done2",  {63'd0, done},      64'd0);
      key_complete = 1'b1;
      tick();
      check_eq("t2_done",   {63'd0, done},   64'd1);
      check_eq("t2_status", {62'd0, status}, 64'd0);
      key_complete = 1'b0;
      tick();
      check_eq("t2_done_pulse", {63'd0, done},      64'd0);
      check_eq("t2_idle",       {63'd0, cmd_ready}, 64'd1);

      // ---------------- LOAD with ready 1-of-3 ----------------
      for (int i = 0; i < KW; i++) kbuf_write(6'(i), buf3[i]);
      key_ready = 1'b0;
      issue(2'b00);
      exp_idx = 0;
      for (int c = 0; c < 60 && exp_idx < KW; c++) begin
         key_ready = ((c % 3) == 2);
         check_eq("t3_valid", {63'd0, key_valid}, 64'd1);
         check_eq("t3_data",  key_data,           buf3[exp_idx]);
         if (key_valid && key_ready) exp_idx++;
         tick();
      end
      key_ready = 1'b0;
      check_eq("t3_words", 64'(exp_idx), 64'(KW));
      check_eq("t3_valid_low", {63'd0, key_valid}, 64'd0);
      key_complete = 1'b1;
      wait_done(40);
      check_eq("t3_status", {62'd0, status}, 64'd0);
      key_complete = 1'b0;
      tick();

      // ---------------- timeout, ready never high ----------------
      issue(2'b00);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!key_valid) break;
         cnt++;
         tick();
      end
      check_eq("t4_valid_cycles", 64'(cnt), 64'(TMO));
      check_eq("t4_done",   {63'd0, done},   64'd1);
      check_eq("t4_status", {62'd0, status}, 64'd1);
      tick();
      check_eq("t4_done_pulse", {63'd0, done}, 64'd0);

      // ---------------- CLEAR, ack 3 cycles after request ----------------
      key_ready = 1'b1;   // must be ignored during CLEAR
      issue(2'b01);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!clear_key) break;
         cnt++;
         check_eq("t5_no_valid", {63'd0, key_valid}, 64'd0);
         if (cnt == 4) clear_ack = 1'b1;
         tick();
      end
      clear_ack = 1'b0;
      check_eq("t5_clear_cycles", 64'(cnt), 64'd4);
      check_eq("t5_done",   {63'd0, done},   64'd1);
      check_eq("t5_status", {62'd0, status}, 64'd0);
      tick();

      // ---------------- early complete after word 2 ----------------
      key_ready = 1'b1;
      issue(2'b00);
      tick(); tick();
      check_eq("t5b_data2", key_data, buf3[2]);
      key_complete = 1'b1;
      tick();
      check_eq("t5b_done",   {63'd0, done},      64'd1);
      check_eq("t5b_status", {62'd0, status},    64'd2);
      check_eq("t5b_valid",  {63'd0, key_valid}, 64'd0);
      key_complete = 1'b0;
      key_ready    = 1'b0;
      tick();

      // ---------------- illegal op ----------------
      issue(2'b11);
      check_eq("t6_done",   {63'd0, done},      64'd1);
      check_eq("t6_status", {62'd0, status},    64'd3);
      check_eq("t6_ready",  {63'd0, cmd_ready}, 64'd0);
      tick();
      check_eq("t6_idle",   {63'd0, cmd_ready}, 64'd1);

      // ---------------- writes/commands while busy are dropped ----------------
      issue(2'b00);
      kbuf_write(6'd0, 64'hDEAD_BEEF_DEAD_BEEF);
      cmd_valid = 1'b1; cmd_op = 2'b01;
      tick();
      cmd_valid = 1'b0; cmd_op = 2'b00;
      check_eq("t6_busy_data", key_data, buf3[0]);
      wait_done(40);
      check_eq("t6_tmo_status", {62'd0, status}, 64'd1);
      tick();
      check_eq("t6_not_queued", {63'd0, clear_key}, 64'd0);
      tick();
      check_eq("t6_still_idle", {63'd0, busy}, 64'd0);
      kbuf_write(6'd8, 64'h0BAD_0BAD_0BAD_0BAD);   // out of range, must not alias word 0
      key_ready = 1'b1;
      issue(2'b00);
      for (int i = 0; i < KW; i++) begin
         check_eq("t6_reload", key_data, buf3[i]);
         tick();
      end
      key_ready    = 1'b0;
      key_complete = 1'b1;
      wait_done(40);
      check_eq("t6_reload_status", {62'd0, status}, 64'd0);
      key_complete = 1'b0;
      tick();

      // ---------------- asynchronous reset mid-SEND ----------------
      issue(2'b00);
      tick(); tick();
      check_eq("t1_valid_pre", {63'd0, key_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t1_valid",     {63'd0, key_valid}, 64'd0);
      check_eq("t1_clear",     {63'd0, clear_key}, 64'd0);
      check_eq("t1_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check_eq("t1_done",      {63'd0, done},      64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // ---------------- asynchronous reset mid-CLEAR ----------------
      issue(2'b01);
      check_eq("t1c_clear_pre", {63'd0, clear_key}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t1c_clear", {63'd0, clear_key}, 64'd0);
      check_eq("t1c_busy",  {63'd0, busy},      64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
